// File: rtl/row_window_feeder.sv
// row_window_feeder
//
// Double-buffered window assembler. Pixels stream in row-major order and
// fill a kx x W window in one of two banks. A complete bank is presented on
// pixel_row until the consumer pulses window_done. While one bank is being
// consumed, the other can fill, so input throughput stays at one pixel per
// cycle as long as a bank is available.
//
// Handshake: a pixel transfers on every rising edge where in_valid and
// in_ready are both 1. in_ready does not depend on in_valid. The window
// side is not a valid/ready pair. pixel_ready=1 means pixel_row is complete
// and stable. A window_done pulse in a cycle with pixel_ready=1 releases
// that window at the edge. A window_done pulse with pixel_ready=0 changes no
// state and only sets the sticky err_underflow.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   in_pixel        streamed pixel (RES bits)
//   in_valid        in_pixel is valid
//   in_ready        block accepts in_pixel this cycle
//   flush           synchronous clear of all window state (highest priority)
//   pixel_row       presented window, [row][column]
//   pixel_ready     pixel_row holds a complete window
//   window_done     consumer finished the presented window
//   windows_pending number of FULL banks (0..2)
//   err_underflow   sticky: window_done seen with no window presented
module row_window_feeder #(
  parameter  int kx  = 3,
  parameter  int Pix = 3,
  parameter  int RES = 8,
  localparam int W   = Pix + kx/2 + kx/2,
  localparam int N   = kx * W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [RES-1:0] in_pixel,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           flush,
  output logic [RES-1:0] pixel_row [0:kx-1][0:W-1],
  output logic           pixel_ready,
  input  logic           window_done,
  output logic [1:0]     windows_pending,
  output logic           err_underflow
);

  localparam int RW = (kx > 1) ? $clog2(kx) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  // Per-bank lifecycle: EMPTY -> FILLING -> FULL -> EMPTY (on release).
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  bank_state_t    bank_st   [0:1];
  bank_state_t    bank_st_n [0:1];
  logic           wr_bank, wr_bank_n;
  logic           rd_bank, rd_bank_n;
  logic [RW-1:0]  wr_row, wr_row_n;
  logic [CW-1:0]  wr_col, wr_col_n;
  logic           err_n;

  logic [RES-1:0] mem [0:1][0:kx-1][0:W-1];

  logic           accept;
  logic           last_pix;

  // A FULL write bank blocks input. This is what keeps the presented
  // window from being overwritten.
  assign in_ready    = (bank_st[wr_bank] != FULL) && !flush;
  assign accept      = in_valid && in_ready;
  assign last_pix    = (wr_row == RW'(kx - 1)) && (wr_col == CW'(W - 1));
  assign pixel_ready = (bank_st[rd_bank] == FULL);

  assign windows_pending = {1'b0, bank_st[0] == FULL} + {1'b0, bank_st[1] == FULL};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0]    <= EMPTY;
      bank_st[1]    <= EMPTY;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_row        <= '0;
      wr_col        <= '0;
      err_underflow <= 1'b0;
    end else begin
      bank_st[0]    <= bank_st_n[0];
      bank_st[1]    <= bank_st_n[1];
      wr_bank       <= wr_bank_n;
      rd_bank       <= rd_bank_n;
      wr_row        <= wr_row_n;
      wr_col        <= wr_col_n;
      err_underflow <= err_n;
    end
  end

  // Next-state logic. A release and an accept can happen on the same edge.
  // They always hit different banks, because the released bank is FULL and
  // a FULL bank is never the accepting bank. So both updates apply
  // independently.
  always_comb begin
    bank_st_n[0] = bank_st[0];
    bank_st_n[1] = bank_st[1];
    wr_bank_n    = wr_bank;
    rd_bank_n    = rd_bank;
    wr_row_n     = wr_row;
    wr_col_n     = wr_col;
    err_n        = err_underflow;

    if (flush) begin
      bank_st_n[0] = EMPTY;
      bank_st_n[1] = EMPTY;
      wr_bank_n    = 1'b0;
      rd_bank_n    = 1'b0;
      wr_row_n     = '0;
      wr_col_n     = '0;
      err_n        = 1'b0;
    end else begin
      if (window_done) begin
        if (pixel_ready) begin
          bank_st_n[rd_bank] = EMPTY;
          rd_bank_n          = ~rd_bank;
        end else begin
          err_n = 1'b1;
        end
      end

      if (accept) begin
        if (last_pix) begin
          bank_st_n[wr_bank] = FULL;
          wr_row_n           = '0;
          wr_col_n           = '0;
          wr_bank_n          = ~wr_bank;
        end else begin
          bank_st_n[wr_bank] = FILLING;
          if (wr_col == CW'(W - 1)) begin
            wr_col_n = '0;
            wr_row_n = wr_row + RW'(1);
          end else begin
            wr_col_n = wr_col + CW'(1);
          end
        end
      end
    end
  end

  // Pixel storage. Flush leaves the contents alone. A bank's contents are
  // only visible once the bank has been completely rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < kx; r++)
          for (int c = 0; c < W; c++)
            mem[b][r][c] <= '0;
    end else if (accept) begin
      mem[wr_bank][wr_row][wr_col] <= in_pixel;
    end
  end

  // The presented window is the read bank, taken combinationally. It stays
  // stable while pixel_ready=1 because that bank cannot be written.
  always_comb begin
    for (int r = 0; r < kx; r++)
      for (int c = 0; c < W; c++)
        pixel_row[r][c] = mem[rd_bank][r][c];
  end

endmodule

// File: tb/tb_row_window_feeder.sv
// Testbench for row_window_feeder at default parameters.
// The reference model holds a queue of completed windows (oldest is the one
// presented) plus a list of the pixels accepted so far for the next window.
module tb_row_window_feeder;

  localparam int KX  = 3;
  localparam int PIX = 3;
  localparam int RES = 8;
  localparam int WW  = PIX + KX/2 + KX/2;
  localparam int NN  = KX * WW;
  localparam int MW  = NN * RES;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [RES-1:0] in_pixel;
  logic           in_valid;
  logic           in_ready;
  logic           flush;
  logic [RES-1:0] pixel_row [0:KX-1][0:WW-1];
  logic           pixel_ready;
  logic           window_done;
  logic [1:0]     windows_pending;
  logic           err_underflow;

  row_window_feeder #(.kx(KX), .Pix(PIX), .RES(RES)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_pixel        (in_pixel),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .flush           (flush),
    .pixel_row       (pixel_row),
    .pixel_ready     (pixel_ready),
    .window_done     (window_done),
    .windows_pending (windows_pending),
    .err_underflow   (err_underflow)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [MW-1:0]  exp_q [$];
  logic [RES-1:0] part_q [$];
  logic           m_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] flat_window();
    logic [MW-1:0] v;
    v = '0;
    for (int r = 0; r < KX; r++)
      for (int c = 0; c < WW; c++)
        v[(r*WW + c)*RES +: RES] = pixel_row[r][c];
    return v;
  endfunction

  function automatic logic [MW-1:0] ramp_window(input int base);
    logic [MW-1:0] v;
    for (int i = 0; i < NN; i++) v[i*RES +: RES] = RES'(base + i);
    return v;
  endfunction

  function automatic logic model_in_ready(input logic f);
    return (exp_q.size() < 2) && !f;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    part_q.delete();
    m_err = 1'b0;
  endtask

  task automatic check_outputs(input logic f);
    chk("pixel_ready", MW'(pixel_ready), MW'(exp_q.size() > 0));
    chk("windows_pending", MW'(windows_pending), MW'(exp_q.size()));
    chk("err_underflow", MW'(err_underflow), MW'(m_err));
    chk("in_ready", MW'(in_ready), MW'(model_in_ready(f)));
    if (exp_q.size() > 0) chk("pixel_row", flat_window(), exp_q[0]);
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; drives, checks in_ready, clocks, checks.
  task automatic cycle(input logic v, input logic [RES-1:0] p, input logic d, input logic f);
    logic acc;
    logic [MW-1:0] win;
    in_valid = v; in_pixel = p; window_done = d; flush = f;
    #1;
    chk("in_ready_pre", MW'(in_ready), MW'(model_in_ready(f)));
    acc = v && model_in_ready(f);
    @(posedge clk);
    if (f) begin
      model_clear();
    end else begin
      if (d) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else m_err = 1'b1;
      end
      if (acc) begin
        part_q.push_back(p);
        if (part_q.size() == NN) begin
          for (int i = 0; i < NN; i++) win[i*RES +: RES] = part_q[i];
          exp_q.push_back(win);
          part_q.delete();
        end
      end
    end
    #1;
    check_outputs(f);
  endtask

  task automatic stream(input int base, input int count, input logic done_last);
    for (int i = 0; i < count; i++)
      cycle(1'b1, RES'(base + i), done_last && (i == count - 1), 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_pixel = '0; window_done = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #2;
    model_clear();
    chk("rst_in_ready", MW'(in_ready), MW'(1));
    chk("rst_pixel_ready", MW'(pixel_ready), MW'(0));
    chk("rst_pending", MW'(windows_pending), MW'(0));
    chk("rst_err", MW'(err_underflow), MW'(0));
    chk("rst_contents", flat_window(), MW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic           v;
    logic [RES-1:0] p;
    logic           d;
    logic           f;
    logic           e_pr;
    logic           e_ir;
    logic [1:0]     e_wp;
    logic           e_err;
  } vec_t;

  vec_t tbl [6];

  initial begin
    // underflow / flush table, applied straight after reset
    tbl[0] = '{v:1'b0, p:8'd0,  d:1'b1, f:1'b0, e_pr:1'b0, e_ir:1'b1, e_wp:2'd0, e_err:1'b1};
    tbl[1] = '{v:1'b1, p:8'd55, d:1'b0, f:1'b0, e_pr:1'b0, e_ir:1'b1, e_wp:2'd0, e_err:1'b1};
    tbl[2] = '{v:1'b0, p:8'd0,  d:1'b1, f:1'b1, e_pr:1'b0, e_ir:1'b0, e_wp:2'd0, e_err:1'b0};
    tbl[3] = '{v:1'b0, p:8'd0,  d:1'b0, f:1'b0, e_pr:1'b0, e_ir:1'b1, e_wp:2'd0, e_err:1'b0};
    tbl[4] = '{v:1'b0, p:8'd0,  d:1'b1, f:1'b0, e_pr:1'b0, e_ir:1'b1, e_wp:2'd0, e_err:1'b1};
    tbl[5] = '{v:1'b0, p:8'd0,  d:1'b0, f:1'b1, e_pr:1'b0, e_ir:1'b0, e_wp:2'd0, e_err:1'b0};

    rst_n = 1'b0;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].v, tbl[i].p, tbl[i].d, tbl[i].f);
      chk($sformatf("tbl%0d_pixel_ready", i), MW'(pixel_ready), MW'(tbl[i].e_pr));
      chk($sformatf("tbl%0d_in_ready", i), MW'(in_ready), MW'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_pending", i), MW'(windows_pending), MW'(tbl[i].e_wp));
      chk($sformatf("tbl%0d_err", i), MW'(err_underflow), MW'(tbl[i].e_err));
    end

    // single window 1..15
    stream(1, 14, 1'b0);
    chk("w1_not_ready_at_14", MW'(pixel_ready), MW'(0));
    stream(15, 1, 1'b0);
    chk("w1_ready", MW'(pixel_ready), MW'(1));
    chk("w1_pending", MW'(windows_pending), MW'(1));
    chk("w1_window", flat_window(), ramp_window(1));

    // backpressure 16..30, then attempted writes are refused
    stream(16, 15, 1'b0);
    chk("bp_in_ready", MW'(in_ready), MW'(0));
    chk("bp_pending", MW'(windows_pending), MW'(2));
    chk("bp_window", flat_window(), ramp_window(1));
    cycle(1'b1, 8'd99, 1'b0, 1'b0);
    cycle(1'b1, 8'd98, 1'b0, 1'b0);
    chk("bp_window_held", flat_window(), ramp_window(1));

    // release
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    chk("rel_window", flat_window(), ramp_window(16));
    chk("rel_pending", MW'(windows_pending), MW'(1));
    chk("rel_in_ready", MW'(in_ready), MW'(1));

    // simultaneous release + last accept
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    stream(1, 15, 1'b0);
    stream(16, 14, 1'b0);
    cycle(1'b1, 8'd30, 1'b1, 1'b0);
    chk("sim_pending", MW'(windows_pending), MW'(1));
    chk("sim_window", flat_window(), ramp_window(16));

    // reset mid-fill
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    stream(40, 7, 1'b0);
    do_reset();
    chk("rmid_in_ready", MW'(in_ready), MW'(1));
    chk("rmid_pixel_ready", MW'(pixel_ready), MW'(0));
    stream(101, 15, 1'b0);
    chk("rmid_window", flat_window(), ramp_window(101));
    chk("rmid_pending", MW'(windows_pending), MW'(1));

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) < 7), RES'($urandom_range(0, 255)),
            ($urandom_range(0, 9) < 2), ($urandom_range(0, 99) < 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
